// File: rtl/ddr_bus_bridge.sv
// PicoRV32 native memory port to word-addressed DDR model bridge.
// Byte-strobed writes are emulated with read-modify-write since the DDR port has no byte enables.
module ddr_bus_bridge #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          TIMEOUT   = 16,
  localparam int         AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_valid,
  input  logic [31:0]   mem_addr,
  input  logic [31:0]   mem_wdata,
  input  logic [3:0]    mem_wstrb,
  output logic          mem_ready,
  output logic [31:0]   mem_rdata,
  output logic          bus_err,
  output logic          ddr_rd_req,
  output logic          ddr_wr_req,
  output logic [AW-1:0] ddr_addr,
  output logic [31:0]   ddr_wr_data,
  input  logic [31:0]   ddr_rd_data,
  input  logic          ddr_rd_valid
);

  localparam int          CW   = $clog2(TIMEOUT + 1);
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic          rmw;
  logic [31:0]   off;
  logic          in_range;
  logic [AW-1:0] word;
  logic [31:0]   merged;

  // Unsigned wrap of the subtraction makes addresses below BASE_ADDR decode as out of range.
  assign off      = mem_addr - BASE_ADDR;
  assign in_range = {1'b0, off} < SPAN;
  assign word     = off[AW+1:2];
  assign cnt_nxt  = cnt + 1'b1;

  always_comb begin
    merged = '0;
    for (int i = 0; i < 4; i++)
      merged[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : ddr_rd_data[8*i +: 8];
  end

  // Outputs are set on the transition into the state that presents them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rmw         <= 1'b0;
      mem_ready   <= 1'b0;
      mem_rdata   <= '0;
      bus_err     <= 1'b0;
      ddr_rd_req  <= 1'b0;
      ddr_wr_req  <= 1'b0;
      ddr_addr    <= '0;
      ddr_wr_data <= '0;
    end else begin
      mem_ready  <= 1'b0;
      bus_err    <= 1'b0;
      ddr_rd_req <= 1'b0;
      ddr_wr_req <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_valid && !mem_ready) begin
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
            rmw     <= 1'b0;
            if (!in_range) begin
              state     <= RESP;
              mem_ready <= 1'b1;
              bus_err   <= 1'b1;
              mem_rdata <= '0;
            end else if (mem_wstrb == 4'hF) begin
              state       <= WR_REQ;
              ddr_wr_req  <= 1'b1;
              ddr_addr    <= word;
              ddr_wr_data <= mem_wdata;
            end else begin
              state      <= RD_REQ;
              ddr_rd_req <= 1'b1;
              ddr_addr   <= word;
              rmw        <= |mem_wstrb;
            end
          end
        end
        RD_REQ: begin
          cnt   <= '0;
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          cnt <= cnt_nxt;
          if (ddr_rd_valid) begin
            if (rmw) begin
              state       <= WR_REQ;
              ddr_wr_req  <= 1'b1;
              ddr_wr_data <= merged;
            end else begin
              state     <= RESP;
              mem_ready <= 1'b1;
              mem_rdata <= ddr_rd_data;
            end
          end else if (cnt_nxt == CW'(TIMEOUT)) begin
            state     <= RESP;
            mem_ready <= 1'b1;
            bus_err   <= 1'b1;
            mem_rdata <= '0;
          end
        end
        WR_REQ: begin
          state     <= RESP;
          mem_ready <= 1'b1;
          mem_rdata <= '0;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_bus_bridge.sv
// Bench for ddr_bus_bridge: behavioural DDR model, scoreboard of expected completions,
// vector table plus hand sequences for timeout, reset and stray-valid corners.
module tb_ddr_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        bus_err;
  logic        ddr_rd_req;
  logic        ddr_wr_req;
  logic [9:0]  ddr_addr;
  logic [31:0] ddr_wr_data;
  logic [31:0] ddr_rd_data;
  logic        ddr_rd_valid;

  ddr_bus_bridge dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .bus_err(bus_err),
    .ddr_rd_req(ddr_rd_req), .ddr_wr_req(ddr_wr_req), .ddr_addr(ddr_addr),
    .ddr_wr_data(ddr_wr_data), .ddr_rd_data(ddr_rd_data), .ddr_rd_valid(ddr_rd_valid)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  // DDR model: read data after rd_delay cycles (1 = next cycle), optional withholding.
  logic [31:0] dmem [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] rd_q = '0;
  logic        rv_q = 1'b0;
  logic        stray = 1'b0;
  logic        withhold = 1'b0;
  int          rd_delay = 1;
  int          pend = 0;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          ready_cnt = 0;

  assign ddr_rd_data  = rd_q;
  assign ddr_rd_valid = rv_q | stray;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rv_q <= 1'b0;
    if (mem_ready) ready_cnt <= ready_cnt + 1;
    if (ddr_rd_req) rd_cnt <= rd_cnt + 1;
    if (ddr_wr_req) begin
      wr_cnt <= wr_cnt + 1;
      dmem[ddr_addr] <= ddr_wr_data;
    end
    if (ddr_rd_req && ddr_wr_req) begin
      total_cnt <= total_cnt + 1;
      $display("FAIL rd_wr_overlap: got both requests high expected one");
    end
    if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1) rv_q <= 1'b1;
    end
    if (ddr_rd_req && !withhold) begin
      rd_q <= dmem[ddr_addr];
      if (rd_delay == 1) rv_q <= 1'b1;
      else pend <= rd_delay - 1;
    end
  end

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          start;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (mem_ready) begin
      if (sb.size() == 0) chk("unexpected_ready", 32'(mem_ready), 32'd0);
      else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_rdata"}, mem_rdata, mon_e.rdata);
        chk({mon_e.name, "_err"}, 32'(bus_err), 32'(mon_e.err));
        chk({mon_e.name, "_lat"}, 32'(cyc - mon_e.start), 32'(mon_e.lat));
      end
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? nw[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  int          seen_wr_lat, seen_rd_lat;
  logic [9:0]  seen_wr_addr;
  logic [31:0] seen_wr_data;

  task automatic do_op(input string n, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] er, input logic ee, input int el);
    exp_t e;
    bit   done;
    @(negedge clk);
    mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_valid = 1'b1;
    e.name = n; e.rdata = er; e.err = ee; e.lat = el; e.start = cyc;
    sb.push_back(e);
    seen_wr_lat = -1; seen_rd_lat = -1; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (ddr_wr_req) begin
        seen_wr_lat = cyc - e.start; seen_wr_addr = ddr_addr; seen_wr_data = ddr_wr_data;
      end
      if (ddr_rd_req) seen_rd_lat = cyc - e.start;
      if (mem_ready) done = 1'b1;
    end
    mem_valid = 1'b0;
    if (!done) begin
      chk({n, "_no_ready"}, 32'd0, 32'd1);
      if (sb.size() > 0) e = sb.pop_front();
    end
    if (!ee && s != 4'h0) ref_mem[a[11:2]] = merge(ref_mem[a[11:2]], d, s);
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_mem_ready"}, 32'(mem_ready), 32'd0);
    chk({n, "_mem_rdata"}, mem_rdata, 32'd0);
    chk({n, "_bus_err"}, 32'(bus_err), 32'd0);
    chk({n, "_rd_req"}, 32'(ddr_rd_req), 32'd0);
    chk({n, "_wr_req"}, 32'(ddr_wr_req), 32'd0);
    chk({n, "_ddr_addr"}, 32'(ddr_addr), 32'd0);
    chk({n, "_wr_data"}, ddr_wr_data, 32'd0);
  endtask

  typedef struct {
    logic [31:0] a, d;
    logic [3:0]  s;
    logic [31:0] er;
    logic        ee;
    int          el;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          r0, w0, k0, w;
    logic [31:0] a, d, er;
    logic [3:0]  s;
    logic        ee;
    int          el, kind;

    tbl[0]  = '{32'h0000_0FFC, 32'h5A5A_5A5A, 4'hF,    32'h0,         1'b0, 2};
    tbl[1]  = '{32'h0000_0FFC, 32'h0,         4'h0,    32'h5A5A_5A5A, 1'b0, 3};
    tbl[2]  = '{32'h0000_0FFC, 32'h1234_5678, 4'b1000, 32'h0,         1'b0, 4};
    tbl[3]  = '{32'h0000_0FFC, 32'h0,         4'h0,    32'h125A_5A5A, 1'b0, 3};
    tbl[4]  = '{32'h0000_1000, 32'h0,         4'h0,    32'h0,         1'b1, 1};
    tbl[5]  = '{32'hFFFF_FFFC, 32'h0,         4'hF,    32'h0,         1'b1, 1};
    tbl[6]  = '{32'h0000_2003, 32'hDEAD_BEEF, 4'b0001, 32'h0,         1'b1, 1};
    tbl[7]  = '{32'h0000_0000, 32'h0000_00FF, 4'b0001, 32'h0,         1'b0, 4};
    tbl[8]  = '{32'h0000_0003, 32'h0,         4'h0,    32'h0000_00FF, 1'b0, 3};
    tbl[9]  = '{32'h0000_0008, 32'h0102_0304, 4'b0110, 32'h0,         1'b0, 4};
    tbl[10] = '{32'h0000_0008, 32'h0,         4'h0,    32'h0002_0300, 1'b0, 3};

    for (int i = 0; i < 1024; i++) begin dmem[i] = '0; ref_mem[i] = '0; end
    reset = 1'b1; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    // Full write then read of 0x10.
    do_op("wr_full", 32'h10, 32'hCAFE_BABE, 4'hF, 32'h0, 1'b0, 2);
    chk("wr_full_wr_cycle", 32'(seen_wr_lat), 32'd1);
    chk("wr_full_addr", 32'(seen_wr_addr), 32'd4);
    do_op("rd_full", 32'h10, 32'h0, 4'h0, 32'hCAFE_BABE, 1'b0, 3);
    chk("rd_full_rd_cycle", 32'(seen_rd_lat), 32'd1);

    // Partial write merges against preloaded word.
    do_op("preload", 32'h10, 32'h1122_3344, 4'hF, 32'h0, 1'b0, 2);
    do_op("wr_part", 32'h10, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0, 4);
    chk("wr_part_wr_cycle", 32'(seen_wr_lat), 32'd3);
    chk("wr_part_data", seen_wr_data, 32'h11BB_33DD);
    do_op("rd_part", 32'h10, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0, 3);

    // Out of range never touches DDR.
    r0 = rd_cnt; w0 = wr_cnt;
    do_op("oor_rd", 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1, 1);
    @(negedge clk);
    chk("oor_rd_reqs", 32'(rd_cnt - r0), 32'd0);
    chk("oor_wr_reqs", 32'(wr_cnt - w0), 32'd0);

    for (int i = 0; i < 11; i++)
      do_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].er, tbl[i].ee, tbl[i].el);

    // Timeout on plain read and on RMW.
    withhold = 1'b1;
    do_op("to_rd", 32'h20, 32'h0, 4'h0, 32'h0, 1'b1, 18);
    w0 = wr_cnt;
    do_op("to_rmw", 32'h20, 32'hFFFF_FFFF, 4'b0011, 32'h0, 1'b1, 18);
    @(negedge clk);
    chk("to_rmw_no_wr", 32'(wr_cnt - w0), 32'd0);
    withhold = 1'b0;

    // rd_valid in the last waiting cycle wins; one cycle later is a timeout.
    rd_delay = 16;
    do_op("rv_at_limit", 32'h20, 32'h0, 4'h0, ref_mem[8], 1'b0, 18);
    rd_delay = 17;
    do_op("rv_late", 32'h20, 32'h0, 4'h0, 32'h0, 1'b1, 18);
    rd_delay = 1;
    repeat (2) @(negedge clk);

    // Stray rd_valid while idle.
    k0 = ready_cnt;
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (4) @(negedge clk);
    chk("stray_no_ready", 32'(ready_cnt - k0), 32'd0);

    // Random back-to-back stream.
    for (int i = 0; i < 100; i++) begin
      w = $urandom_range(0, 15);
      kind = $urandom_range(0, 9);
      d = $urandom;
      a = 32'(w) << 2;
      ee = 1'b0; er = 32'h0;
      if (kind == 0) begin
        a = 32'h1000 + a; s = 4'(($urandom_range(0, 1) != 0) ? 4'hF : 4'h0);
        ee = 1'b1; el = 1;
      end else if (kind <= 3) begin
        s = 4'h0; er = ref_mem[w]; el = 3;
      end else if (kind <= 6) begin
        s = 4'hF; el = 2;
      end else begin
        s = 4'($urandom_range(1, 14)); el = 4;
      end
      do_op($sformatf("rand%0d", i), a, d, s, er, ee, el);
    end

    // Reset in cycle 2 of a partial write.
    @(negedge clk);
    w0 = wr_cnt; k0 = ready_cnt;
    mem_addr = 32'h10; mem_wdata = 32'hFFFF_FFFF; mem_wstrb = 4'b0101; mem_valid = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1; mem_valid = 1'b0;
    #1;
    chk_zero("rst_mid");
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_mid_no_wr", 32'(wr_cnt - w0), 32'd0);
    chk("rst_mid_no_ready", 32'(ready_cnt - k0), 32'd0);
    do_op("rst_after_rd", 32'h0, 32'h0, 4'h0, ref_mem[0], 1'b0, 3);
    do_op("rst_chk_word4", 32'h10, 32'h0, 4'h0, ref_mem[4], 1'b0, 3);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ddr_bus_bridge.md
Name: ddr_bus_bridge

Overview:
Bridges the PicoRV32 native memory interface (mem_valid/mem_ready) onto the word-addressed DDR memory model port (rd_req/wr_req/addr/wr_data/rd_data/rd_valid).
- Decodes the address window and converts byte addresses to word addresses.
- Emulates byte-strobed writes with read-modify-write, because the DDR port has no byte enables.
- Sits directly upstream of the DDR model; one instance per DDR model.

Parameters:
DEPTH, 1024, DDR size in 32-bit words. AW = $clog2(DEPTH) is derived, not overridable.
BASE_ADDR, 32'h0000_0000, byte base address of the window. Must be a multiple of DEPTH*4.
TIMEOUT, 16, maximum cycles to wait for ddr_rd_valid before flagging an error. Must be >= 2.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
mem_valid  input  1  CPU request valid; held until mem_ready
mem_addr  input  32  CPU byte address; bits [1:0] ignored
mem_wdata  input  32  CPU write data
mem_wstrb  input  4  byte strobes; 0 = read
mem_ready  output  1  one-cycle completion pulse
mem_rdata  output  32  read data; valid while mem_ready=1
bus_err  output  1  one-cycle pulse coincident with mem_ready on an error completion
ddr_rd_req  output  1  DDR read request
ddr_wr_req  output  1  DDR write request
ddr_addr  output  AW  DDR word address
ddr_wr_data  output  32  DDR write data
ddr_rd_data  input  32  DDR read data
ddr_rd_valid  input  1  DDR read data valid; arrives one cycle after ddr_rd_req

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any time, including mid-transaction):
  - state=IDLE, timeout counter=0;
  - mem_ready=0, mem_rdata=0, bus_err=0, ddr_rd_req=0, ddr_wr_req=0, ddr_addr=0, ddr_wr_data=0.
  - Any in-flight request is dropped.
  - A ddr_rd_valid arriving after reset is ignored.
- Decode: off = mem_addr - BASE_ADDR (32-bit). The request is in range iff off < DEPTH*4. word = off[AW+1:2].
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP.
- IDLE: accepts a request when mem_valid=1 and mem_ready=0. Latches addr, wdata and wstrb, then:
  - out of range -> RESP with rdata=0, err=1; no DDR access.
  - wstrb==0 -> RD_REQ.
  - wstrb==4'hF -> WR_REQ with wr_data=mem_wdata.
  - any other nonzero strobe -> RD_REQ, flagged as RMW.
- RD_REQ: ddr_rd_req=1 for exactly one cycle with ddr_addr=word -> RD_WAIT. Counter cleared.
- RD_WAIT: counter increments each cycle.
  - On ddr_rd_valid=1:
    - plain read -> capture ddr_rd_data into mem_rdata -> RESP.
    - RMW -> merged = per byte i, wstrb[i] ? wdata byte i : rd_data byte i -> WR_REQ.
  - If the counter reaches TIMEOUT without rd_valid -> RESP with rdata=0, err=1. No write is issued for an RMW.
  - If rd_valid arrives in the same cycle the counter reaches TIMEOUT, rd_valid wins.
- WR_REQ: ddr_wr_req=1 for exactly one cycle with ddr_addr=word and ddr_wr_data (full data or merged) -> RESP. mem_rdata=0 for writes.
- RESP: mem_ready=1 for one cycle, plus bus_err if flagged -> IDLE.
  - The CPU drops mem_valid in the cycle after mem_ready, so IDLE does not re-accept the same request.
- ddr_rd_req and ddr_wr_req are never high in the same cycle. ddr_addr and ddr_wr_data hold their last value when idle.
- ddr_rd_valid seen outside RD_WAIT is ignored.
- mem_valid dropping mid-transaction is a protocol violation; the transaction completes regardless.
- Latency, with cycle 0 = the cycle mem_valid is first sampled in IDLE:
  - out-of-range: mem_ready in cycle 1.
  - full-word write: wr_req cycle 1, mem_ready cycle 2.
  - read: rd_req cycle 1, rd_valid cycle 2, mem_ready cycle 3.
  - partial write: rd_req cycle 1, rd_valid cycle 2, wr_req cycle 3, mem_ready cycle 4.
- Back-to-back requests: the next request is accepted in the cycle after RESP (IDLE), at the earliest.

Test Plan:
- Full write then read: write addr 0x10 data 0xCAFEBABE, wstrb=F -> ddr_wr_req in cycle 1 with ddr_addr=4, mem_ready in cycle 2. Then read 0x10 -> mem_ready in cycle 3 with mem_rdata=0xCAFEBABE, bus_err=0.
- Partial write: preload word 4 = 0x11223344; write 0x10 data 0xAABBCCDD, wstrb=4'b0101 -> ddr_wr_data=0x11BB33DD in cycle 3, mem_ready in cycle 4. A subsequent read returns 0x11BB33DD.
- Out of range: BASE_ADDR=0, DEPTH=1024; read 0x1000 -> mem_ready and bus_err in cycle 1, mem_rdata=0, no ddr_rd_req/ddr_wr_req ever asserted.
- Timeout: bench DDR withholds rd_valid on a read -> mem_ready=1, bus_err=1, mem_rdata=0 exactly TIMEOUT=16 cycles after RD_WAIT entry. For an RMW, ddr_wr_req never asserts.
- Reset mid-RMW: assert reset in cycle 2 of a partial write -> all outputs 0 immediately, no wr_req, no mem_ready. Release reset and issue a fresh read of 0x0 -> completes normally in 3 cycles.
- Back-to-back and stray valid: a 100-op random read/write/strobe stream against a scoreboard -> all data matches. A stray ddr_rd_valid pulse injected while in IDLE causes no mem_ready.
